// File: rtl/hazard_control_unit.sv
// Hazard and stall sequencer for the 5-stage RV32 pipeline.
// Drives stage enables, flush/bubble, PC redirect, and stall/flush counters.
module hazard_control_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IFID_RS1,
   input  logic [4:0]       IFID_RS2,
   input  logic             IFID_UseRS2,
   input  logic             IFID_IsBranch,
   input  logic [4:0]       IDEX_RD,
   input  logic             IDEX_RegWrite,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       EXMEM_RD,
   input  logic             EXMEM_MemRead,
   input  logic             branch_taken,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   output logic             PC_write,
   output logic             PC_redirect,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_bubble,
   output logic             EXMEM_write,
   output logic             MEMWB_write,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      ISTALL = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             disc_pend_q, disc_pend_d;
   logic             disc_new_q, disc_new_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic idex_nz, exmem_nz;
   logic idex_m1, idex_m2, exmem_m1, exmem_m2;
   logic lu_haz, br_haz;
   logic stall_inc, flush_inc;

   // x0 is never a real producer, so a zero rd can never match
   assign idex_nz  = (IDEX_RD != 5'd0);
   assign exmem_nz = (EXMEM_RD != 5'd0);
   assign idex_m1  = idex_nz & (IDEX_RD == IFID_RS1);
   assign idex_m2  = idex_nz & (IDEX_RD == IFID_RS2);
   assign exmem_m1 = exmem_nz & (EXMEM_RD == IFID_RS1);
   assign exmem_m2 = exmem_nz & (EXMEM_RD == IFID_RS2);

   assign lu_haz = IDEX_MemRead & (idex_m1 | (IFID_UseRS2 & idex_m2));
   assign br_haz = IFID_IsBranch &
                   ((IDEX_RegWrite & (idex_m1 | idex_m2)) |
                    (EXMEM_MemRead & (exmem_m1 | exmem_m2)));

   always_comb begin
      PC_write    = 1'b1;
      PC_redirect = 1'b0;
      IFID_write  = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
      EXMEM_write = 1'b1;
      MEMWB_write = 1'b1;
      disc_pend_d = disc_pend_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (dcache_stall) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         EXMEM_write = 1'b0;
         MEMWB_write = 1'b0;
         stall_inc   = 1'b1;
      end else if (lu_haz | br_haz) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         stall_inc   = 1'b1;
      end else if (branch_taken) begin
         PC_redirect = 1'b1;
         IFID_flush  = 1'b1;
         flush_inc   = 1'b1;
         disc_pend_d = disc_pend_q | icache_stall;
      end else if (icache_stall) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         stall_inc   = 1'b1;
      end else if (disc_pend_q) begin
         // the wrong-path word arrives now; drop it and hold PC
         PC_write    = 1'b0;
         IFID_flush  = 1'b1;
         disc_pend_d = 1'b0;
      end

      if (!rst_n) begin
         PC_write    = 1'b0;
         PC_redirect = 1'b0;
         IFID_write  = 1'b0;
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
         EXMEM_write = 1'b0;
         MEMWB_write = 1'b0;
      end
   end

   always_comb begin
      state_d = RUN;
      if (dcache_stall) begin
         state_d = FREEZE;
      end else if (icache_stall) begin
         state_d = ISTALL;
      end
      disc_new_d = disc_pend_d & ~disc_pend_q;
      stall_d    = stall_q + CNT_W'(stall_inc);
      flush_d    = flush_q + CNT_W'(flush_inc);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         disc_pend_q <= 1'b0;
         disc_new_q  <= 1'b0;
         stall_q     <= '0;
         flush_q     <= '0;
      end else begin
         state_q     <= state_d;
         disc_pend_q <= disc_pend_d;
         disc_new_q  <= disc_new_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
      end
   end

   // a stale fetch can only be recorded while the I-cache is stalling
   always_ff @(posedge clk) begin
      if (rst_n && disc_new_q) begin
         assert (state_q == ISTALL);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit.
// Checks every cycle against a priority-table reference model.
module tb_hazard_control_unit;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       rs1, rs2, idex_rd, exmem_rd;
   logic             use2, isbr, idex_rw, idex_mr, exmem_mr;
   logic             bt, ic, dc;
   logic             pc_w, pc_r, ifid_w, ifid_f, idex_b;
   logic             exmem_w, memwb_w;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int checks   = 0;
   int failures = 0;

   bit               m_disc;
   logic [CNT_W-1:0] m_stall, m_flush;

   always #5 clk = ~clk;

   hazard_control_unit #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .IFID_RS1     (rs1),
      .IFID_RS2     (rs2),
      .IFID_UseRS2  (use2),
      .IFID_IsBranch(isbr),
      .IDEX_RD      (idex_rd),
      .IDEX_RegWrite(idex_rw),
      .IDEX_MemRead (idex_mr),
      .EXMEM_RD     (exmem_rd),
      .EXMEM_MemRead(exmem_mr),
      .branch_taken (bt),
      .icache_stall (ic),
      .dcache_stall (dc),
      .PC_write     (pc_w),
      .PC_redirect  (pc_r),
      .IFID_write   (ifid_w),
      .IFID_flush   (ifid_f),
      .IDEX_bubble  (idex_b),
      .EXMEM_write  (exmem_w),
      .MEMWB_write  (memwb_w),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // which rule governs this cycle: 0 reset, 1..5 priorities, 6 normal
   function automatic int prio();
      bit lu, br;
      lu = idex_mr && idex_rd != 0 &&
           (idex_rd == rs1 || (use2 && idex_rd == rs2));
      br = isbr &&
           ((idex_rw && idex_rd != 0 &&
             (idex_rd == rs1 || idex_rd == rs2)) ||
            (exmem_mr && exmem_rd != 0 &&
             (exmem_rd == rs1 || exmem_rd == rs2)));
      if (!rst_n) return 0;
      if (dc) return 1;
      if (lu || br) return 2;
      if (bt) return 3;
      if (ic) return 4;
      if (m_disc) return 5;
      return 6;
   endfunction

   // {PC_write,PC_redirect,IFID_write,IFID_flush,IDEX_bubble,EXMEM_write,MEMWB_write}
   function automatic logic [6:0] exp_out(input int p);
      case (p)
         0:       return 7'b0001100;
         1:       return 7'b0000000;
         2:       return 7'b0000111;
         3:       return 7'b1111011;
         4:       return 7'b0000111;
         5:       return 7'b0011011;
         default: return 7'b1010011;
      endcase
   endfunction

   task automatic drive(input logic [4:0] a, input logic [4:0] b,
                        input logic u, input logic br_,
                        input logic [4:0] xr, input logic rw,
                        input logic mr, input logic [4:0] mrd,
                        input logic mmr, input logic t,
                        input logic i, input logic d);
      rs1 = a; rs2 = b; use2 = u; isbr = br_;
      idex_rd = xr; idex_rw = rw; idex_mr = mr;
      exmem_rd = mrd; exmem_mr = mmr;
      bt = t; ic = i; dc = d;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step(input string tag);
      int p;
      p = prio();
      #3;
      chk({tag, ":out"},
          {25'd0, pc_w, pc_r, ifid_w, ifid_f, idex_b, exmem_w, memwb_w},
          {25'd0, exp_out(p)});
      @(posedge clk);
      #1;
      case (p)
         0: begin
            m_disc  = 1'b0;
            m_stall = '0;
            m_flush = '0;
         end
         1, 2, 4: m_stall = m_stall + 1;
         3: begin
            m_flush = m_flush + 1;
            m_disc  = m_disc | ic;
         end
         5: m_disc = 1'b0;
         default: ;
      endcase
      chk({tag, ":stall"}, stall_cycles, m_stall);
      chk({tag, ":flush"}, flush_count, m_flush);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      step("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      m_disc  = 1'b0;
      m_stall = '0;
      m_flush = '0;

      do_reset();
      chk("reset_stall", stall_cycles, 32'd0);
      chk("reset_flush", flush_count, 32'd0);

      // lw x5 in EX, add x6,x5,x1 in ID
      drive(5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lu_hit");
      idle();
      step("lu_after");
      chk("lu_total", stall_cycles, 32'd1);

      // lw x5 then beq x5,x0
      do_reset();
      drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lb_c1");
      drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lb_c2");
      drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lb_c3");
      chk("lb_total", stall_cycles, 32'd2);

      // same sequence with rd = x0: never a hazard
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lb0_c1");
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lb0_c2");
      chk("lb0_total", stall_cycles, 32'd2);

      // taken branch, no stalls
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("bt");
      idle();
      step("bt_after");
      chk("bt_flush", flush_count, 32'd1);

      // taken branch under a 3-cycle I-cache stall
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("bti_c1");
      idle();
      ic = 1'b1;
      step("bti_c2");
      step("bti_c3");
      ic = 1'b0;
      step("bti_drop");
      step("bti_norm");
      chk("bti_stall", stall_cycles, 32'd2);
      chk("bti_flush", flush_count, 32'd1);

      // D-cache stall over a load-use hazard
      do_reset();
      drive(5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1,
            5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) step("dc_frz");
      dc = 1'b0;
      step("dc_lu");
      idle();
      step("dc_after");
      chk("dc_total", stall_cycles, 32'd5);

      // reset while a stale fetch is pending
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0,
            5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("rd_c1");
      idle();
      ic = 1'b1;
      step("rd_c2");
      rst_n = 1'b0;
      step("rd_rst");
      rst_n = 1'b1;
      ic = 1'b0;
      step("rd_rel");
      chk("rd_stall", stall_cycles, 32'd0);
      chk("rd_flush", flush_count, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         rs1      = 5'($urandom_range(0, 7));
         rs2      = 5'($urandom_range(0, 7));
         use2     = 1'($urandom_range(0, 1));
         isbr     = ($urandom_range(0, 2) == 0);
         idex_rd  = 5'($urandom_range(0, 7));
         idex_rw  = 1'($urandom_range(0, 1));
         idex_mr  = ($urandom_range(0, 3) == 0);
         exmem_rd = 5'($urandom_range(0, 7));
         exmem_mr = ($urandom_range(0, 3) == 0);
         bt       = ($urandom_range(0, 3) == 0);
         ic       = ($urandom_range(0, 3) == 0);
         dc       = ($urandom_range(0, 7) == 0);
         step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
